// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing front end for the 32x32 shift-add multiplier (MUL/MULH/MULHSU/MULHU).
// Converts signed operands to magnitudes, issues the core, sign-corrects and returns a tagged result.
module mul_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_op,
  input  logic [31:0]      i_req_rs1,
  input  logic [31:0]      i_req_rs2,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [31:0]      o_resp_data,
  output logic [TAG_W-1:0] o_resp_tag,
  output logic             o_resp_err,
  output logic             o_mul_start,
  output logic [31:0]      o_mul_a,
  output logic [31:0]      o_mul_b,
  input  logic [63:0]      i_mul_result,
  input  logic             i_mul_done
);

  // state | meaning: IDLE accept | ISSUE start pulse | GUARD mask stale done | WAIT done/timeout | RESP hold result
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             r_state;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic [31:0]        r_resp_data;
  logic [TAG_W-1:0]   r_resp_tag;
  logic               r_resp_err;
  logic               r_mul_start;
  logic [31:0]        r_mul_a;
  logic [31:0]        r_mul_b;
  logic               r_hi;
  logic               r_neg;
  logic [TMR_W-1:0]   r_tmr;

  logic               w_sign_a;
  logic               w_sign_b;
  logic [31:0]        w_mag_a;
  logic [31:0]        w_mag_b;
  logic               w_zero;
  logic               w_accept;
  logic [63:0]        w_prod;
  logic [31:0]        w_res;

  assign w_sign_a = i_req_rs1[31] & ((i_req_op == 2'b01) | (i_req_op == 2'b10));
  assign w_sign_b = i_req_rs2[31] & (i_req_op == 2'b01);
  assign w_mag_a  = w_sign_a ? (~i_req_rs1 + 32'd1) : i_req_rs1;
  assign w_mag_b  = w_sign_b ? (~i_req_rs2 + 32'd1) : i_req_rs2;
  assign w_zero   = (i_req_rs1 == 32'd0) | (i_req_rs2 == 32'd0);
  assign w_accept = (r_state == S_IDLE) & r_req_ready & i_req_valid;

  assign w_prod = r_neg ? (~i_mul_result + 64'd1) : i_mul_result;
  assign w_res  = r_hi ? w_prod[63:32] : w_prod[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_tag   <= '0;
      r_resp_err   <= 1'b0;
      r_mul_start  <= 1'b0;
      r_mul_a      <= 32'd0;
      r_mul_b      <= 32'd0;
      r_hi         <= 1'b0;
      r_neg        <= 1'b0;
      r_tmr        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_hi        <= (i_req_op != 2'b00);
            r_neg       <= w_sign_a ^ w_sign_b;
            r_resp_tag  <= i_req_tag;
            if (w_zero) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= 32'd0;
              r_resp_err   <= 1'b0;
              r_state      <= S_RESP;
            end else begin
              r_mul_a     <= w_mag_a;
              r_mul_b     <= w_mag_b;
              r_mul_start <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_mul_start <= 1'b0;
          r_state     <= S_GUARD;
        end
        S_GUARD: begin
          r_tmr   <= TMR_W'(TIMEOUT_CYCLES - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // done wins over the timeout when both land on the last WAIT cycle
          if (i_mul_done) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_res;
            r_resp_err   <= 1'b0;
            r_state      <= S_RESP;
          end else if (r_tmr == '0) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= 32'd0;
            r_resp_err   <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_tag   = r_resp_tag;
  assign o_resp_err   = r_resp_err;
  assign o_mul_start  = r_mul_start;
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomized bench for mul_issue_ctrl: multiplier core model plus a RISC-V-semantics reference
// model; one compare process checks handshakes, timing, data and hold behaviour every cycle.
module tb_mul_issue_ctrl;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [1:0]       i_req_op;
  logic [31:0]      i_req_rs1;
  logic [31:0]      i_req_rs2;
  logic [TAG_W-1:0] i_req_tag;
  logic             o_resp_valid;
  logic             i_resp_ready;
  logic [31:0]      o_resp_data;
  logic [TAG_W-1:0] o_resp_tag;
  logic             o_resp_err;
  logic             o_mul_start;
  logic [31:0]      o_mul_a;
  logic [31:0]      o_mul_b;
  logic [63:0]      i_mul_result;
  logic             i_mul_done;

  mul_issue_ctrl #(.TIMEOUT_CYCLES(40), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
    .i_req_rs1(i_req_rs1), .i_req_rs2(i_req_rs2), .i_req_tag(i_req_tag),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_resp_data(o_resp_data),
    .o_resp_tag(o_resp_tag), .o_resp_err(o_resp_err),
    .o_mul_start(o_mul_start), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
    .i_mul_result(i_mul_result), .i_mul_done(i_mul_done)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               delta;
    int               starts;
    logic [31:0]      ma;
    logic [31:0]      mb;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   cur_act = 0;
  bit   cur_seen = 0;
  int   cur_acc = 0;
  int   cur_starts = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic [31:0]      last_data;
  logic             last_err;
  logic [TAG_W-1:0] last_tag;
  int   last_delta, last_starts;

  // Reference: architectural result computed with 64-bit extended operands.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic exp_t make_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [TAG_W-1:0] tag, input int lat, input bit stuck);
    exp_t e;
    e.tag = tag;
    e.ma  = (a[31] && (op == 2'd1 || op == 2'd2)) ? (32'd0 - a) : a;
    e.mb  = (b[31] && op == 2'd1) ? (32'd0 - b) : b;
    if (a == 0 || b == 0) begin
      e.data = 0; e.err = 0; e.delta = 0; e.starts = 0;
    end else if (stuck || lat > 41) begin
      e.data = 0; e.err = 1; e.delta = 42; e.starts = 1;
    end else begin
      e.data = ref_res(op, a, b); e.err = 0; e.delta = lat + 1; e.starts = 1;
    end
    return e;
  endfunction

  // Multiplier core model: done/result appear core_lat negedges after start is seen;
  // the previous done stays high until two negedges after the new start.
  int          core_lat = 10;
  bit          core_stuck = 0;
  int          c_cnt = 0;
  int          c_clr = 0;
  logic [63:0] c_prod = 0;

  initial begin
    i_mul_done = 1'b0;
    i_mul_result = 64'd0;
    forever begin
      @(negedge clk);
      if (c_clr > 0) begin
        c_clr--;
        if (c_clr == 0) i_mul_done = 1'b0;
      end
      if (o_mul_start) begin
        c_clr  = 2;
        c_cnt  = core_lat;
        c_prod = 64'(o_mul_a) * 64'(o_mul_b);
      end else if (c_cnt > 0) begin
        c_cnt--;
        if (c_cnt == 0 && !core_stuck) begin
          i_mul_done   = 1'b1;
          i_mul_result = c_prod;
        end
      end
    end
  end

  // Compare process: samples 1 time unit after every rising edge.
  initial begin
    bit prev_rdy, prev_valid;
    prev_rdy = 0; prev_valid = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        prev_rdy = 0; prev_valid = 0; cur_act = 0;
        continue;
      end
      if (prev_valid && i_resp_ready && cur_act) begin
        chk("start_count", 64'(cur_starts), 64'(cur.starts));
        last_starts = cur_starts;
        done_cnt++;
        cur_act = 0;
      end
      if (prev_rdy && i_req_valid) begin
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          cur_act = 1; cur_seen = 0; cur_acc = cyc; cur_starts = 0;
        end else chk("unexpected_accept", 1, 0);
      end
      if (o_mul_start) begin
        if (!cur_act) chk("spurious_start", 1, 0);
        else begin
          cur_starts++;
          chk("start_cycle", 64'(cyc - cur_acc), 0);
        end
      end
      if (cur_act && cur.starts == 1 && cur_starts > 0 && !cur_seen) begin
        chk("mul_a_hold", o_mul_a, cur.ma);
        chk("mul_b_hold", o_mul_b, cur.mb);
      end
      if (o_resp_valid) begin
        if (!cur_act) chk("spurious_resp", 1, 0);
        else begin
          if (!cur_seen) begin
            cur_seen = 1;
            chk("resp_latency", 64'(cyc - cur_acc), 64'(cur.delta));
            last_delta = cyc - cur_acc;
            last_data = o_resp_data; last_err = o_resp_err; last_tag = o_resp_tag;
          end
          chk("resp_data", o_resp_data, cur.data);
          chk("resp_tag", o_resp_tag, cur.tag);
          chk("resp_err", o_resp_err, cur.err);
          chk("req_ready_in_resp", o_req_ready, 0);
        end
      end else if (cur_act && cur_seen) begin
        chk("resp_dropped", 1, 0);
        cur_act = 0;
      end
      if (cur_act && !cur_seen && (cyc - cur_acc) > 100) begin
        chk("resp_never", 1, 0);
        cur_act = 0;
      end
      prev_rdy = o_req_ready;
      prev_valid = o_resp_valid;
    end
  end

  task automatic send_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input int lat, input bit stuck);
    int i;
    i = 0;
    @(negedge clk);
    while (!o_req_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!o_req_ready) begin
      chk("req_ready_wait", 0, 1);
      return;
    end
    core_lat = lat; core_stuck = stuck;
    exp_q.push_back(make_exp(op, a, b, tag, lat, stuck));
    i_req_op = op; i_req_rs1 = a; i_req_rs2 = b; i_req_tag = tag; i_req_valid = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_req_op = 2'($urandom); i_req_rs1 = $urandom; i_req_rs2 = $urandom; i_req_tag = TAG_W'($urandom);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int lat, input bit stuck, input int bp);
    int d0, i;
    d0 = done_cnt;
    if (bp > 0) i_resp_ready = 1'b0;
    send_req(op, a, b, tag, lat, stuck);
    if (bp > 0) begin
      i = 0;
      while (!o_resp_valid && i < 200) begin
        @(negedge clk);
        i++;
      end
      repeat (bp) @(negedge clk);
      i_resp_ready = 1'b1;
    end
    i = 0;
    while (done_cnt == d0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("resp_handshake", 64'(done_cnt - d0), 1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    logic [31:0] a, b;
    int lat;
    i_req_valid = 0; i_req_op = 0; i_req_rs1 = 0; i_req_rs2 = 0; i_req_tag = 0; i_resp_ready = 1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_resp_data", o_resp_data, 0);
    chk("rst_resp_tag", o_resp_tag, 0);
    chk("rst_resp_err", o_resp_err, 0);
    chk("rst_mul_start", o_mul_start, 0);
    chk("rst_mul_a", o_mul_a, 0);
    chk("rst_mul_b", o_mul_b, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2 chk("req_ready_after_rst", o_req_ready, 1);

    run_op(2'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 30, 0, 0);
    chk("lit_mul", last_data, 32'hFFFF_FFEB);
    chk("lit_mul_tag", last_tag, 5'd3);
    chk("lit_mul_starts", 64'(last_starts), 1);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 33, 0, 0);
    chk("lit_mulh_min", last_data, 32'h4000_0000);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 20, 0, 0);
    chk("lit_mulh_m1", last_data, 32'h0000_0000);
    run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 25, 0, 0);
    chk("lit_mulhsu", last_data, 32'hFFFF_FFFF);
    run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 3, 0, 0);
    chk("lit_mulhu", last_data, 32'hFFFF_FFFE);

    run_op(2'd3, 32'd0, 32'd5, 5'd9, 20, 0, 0);
    chk("lit_bypass_data", last_data, 0);
    chk("lit_bypass_tag", last_tag, 5'd9);
    chk("lit_bypass_lat", 64'(last_delta), 0);
    chk("lit_bypass_starts", 64'(last_starts), 0);

    run_op(2'd0, 32'd1000, 32'd3, 5'd10, 10, 0, 0);
    run_op(2'd0, 32'd6, 32'd7, 5'd11, 3, 0, 10);
    chk("lit_stale_bp", last_data, 32'd42);

    run_op(2'd3, 32'd12, 32'd12, 5'd12, 10, 1, 0);
    chk("lit_timeout_err", last_err, 1);
    chk("lit_timeout_data", last_data, 0);
    chk("lit_timeout_lat", 64'(last_delta), 42);
    run_op(2'd0, 32'd9, 32'd9, 5'd13, 41, 0, 0);
    chk("lit_tie_err", last_err, 0);
    chk("lit_tie_data", last_data, 32'd81);
    run_op(2'd0, 32'd9, 32'd9, 5'd14, 42, 0, 0);
    chk("lit_late_err", last_err, 1);

    send_req(2'd1, 32'h1234_5678, 32'hF000_0001, 5'd15, 60, 0);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", o_req_ready, 0);
    chk("mid_rst_resp_valid", o_resp_valid, 0);
    chk("mid_rst_resp_data", o_resp_data, 0);
    chk("mid_rst_resp_tag", o_resp_tag, 0);
    chk("mid_rst_resp_err", o_resp_err, 0);
    chk("mid_rst_mul_start", o_mul_start, 0);
    chk("mid_rst_mul_a", o_mul_a, 0);
    chk("mid_rst_mul_b", o_mul_b, 0);
    exp_q.delete();
    cur_act = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(2'd1, 32'hFFFF_FFF0, 32'd100, 5'd16, 12, 0, 0);
    chk("lit_after_rst", last_data, 32'hFFFF_FFFF);

    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom);
      a = pick_operand();
      b = pick_operand();
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 44) : $urandom_range(3, 38);
      run_op(op, a, b, TAG_W'($urandom), lat, ($urandom_range(0, 15) == 0), $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 0);
    chk("nothing_in_flight", 64'(cur_act), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
